// File: rtl/des_key_scheduler.sv
// DES key scheduler: PC-1 on start, then 16 round keys via C/D rotation and PC-2.
// Latency: first key one cycle after start is accepted; done pulse 17 cycles after acceptance at full rate.
// Backpressure: rk/rk_round/C/D hold while rk_valid && !rk_ready.
// Optional abort input enabled by defining DES_KEY_SCHEDULER_ABORT_EN.
module des_key_scheduler (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [63:0] key_in,
  input  logic        decrypt,
  input  logic        rk_ready,
`ifdef DES_KEY_SCHEDULER_ABORT_EN
  input  logic        abort,
`endif
  output logic [47:0] rk,
  output logic        rk_valid,
  output logic [3:0]  rk_round,
  output logic        busy,
  output logic        done
);

  // FIPS 46-3 permuted choice tables, 1-based bit numbers (bit 1 = MSB)
  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GEN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic [55:0] pc1_fn(input logic [63:0] k);
    logic [55:0] r;
    r = '0;
    for (int i = 0; i < 56; i++) r[55-i] = k[64-PC1[i]];
    return r;
  endfunction

  function automatic logic [47:0] pc2_fn(input logic [55:0] cd);
    logic [47:0] r;
    r = '0;
    for (int i = 0; i < 48; i++) r[47-i] = cd[56-PC2[i]];
    return r;
  endfunction

  state_t      state_q, state_d;
  logic [27:0] c_q, d_q;
  logic        dec_q;
  logic [3:0]  round_q;
  logic        accept, xfer, abort_i;
  logic [55:0] cd0;
  logic        one_shift;

`ifdef DES_KEY_SCHEDULER_ABORT_EN
  assign abort_i = abort;
`else
  assign abort_i = 1'b0;
`endif

  assign cd0      = pc1_fn(key_in);
  assign rk       = pc2_fn({c_q, d_q});
  assign rk_round = round_q;

  // Rounds 2, 9 and 16 (both directions) use a single-bit rotate; indexed by the current emission
  assign one_shift = (round_q == 4'd0) || (round_q == 4'd7) || (round_q == 4'd14);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state and handshake outputs; abort beats both start and a transfer
  always_comb begin
    state_d  = state_q;
    rk_valid = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    accept   = 1'b0;
    xfer     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !abort_i) begin
          accept  = 1'b1;
          state_d = GEN;
        end
      end
      GEN: begin
        rk_valid = 1'b1;
        busy     = 1'b1;
        if (abort_i) begin
          state_d = IDLE;
        end else if (rk_ready) begin
          xfer = 1'b1;
          if (round_q == 4'd15) state_d = DONE;
        end
      end
      DONE: begin
        busy    = 1'b1;
        done    = !abort_i;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // C/D halves, latched direction and emission counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_q     <= '0;
      d_q     <= '0;
      dec_q   <= 1'b0;
      round_q <= '0;
    end else if (accept) begin
      dec_q   <= decrypt;
      round_q <= '0;
      if (decrypt) begin
        // C0/D0 equals C16/D16, so K16 comes out first
        c_q <= cd0[55:28];
        d_q <= cd0[27:0];
      end else begin
        c_q <= {cd0[54:28], cd0[55]};
        d_q <= {cd0[26:0],  cd0[27]};
      end
    end else if (xfer && (round_q != 4'd15)) begin
      round_q <= round_q + 4'd1;
      if (!dec_q && one_shift) begin
        c_q <= {c_q[26:0], c_q[27]};
        d_q <= {d_q[26:0], d_q[27]};
      end else if (!dec_q) begin
        c_q <= {c_q[25:0], c_q[27:26]};
        d_q <= {d_q[25:0], d_q[27:26]};
      end else if (one_shift) begin
        c_q <= {c_q[0], c_q[27:1]};
        d_q <= {d_q[0], d_q[27:1]};
      end else begin
        c_q <= {c_q[1:0], c_q[27:2]};
        d_q <= {d_q[1:0], d_q[27:2]};
      end
    end
  end

endmodule

// File: tb/tb_des_key_scheduler.sv
// Self-checking bench for des_key_scheduler: known-answer table, random keys and
// random backpressure against a bit-level DES key-schedule model, plus start/reset/abort corners.
module tb_des_key_scheduler;

  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };
  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };
  localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  logic        clk, rst_n, start, decrypt, rk_ready;
  logic [63:0] key_in;
  logic [47:0] rk;
  logic        rk_valid, busy, done;
  logic [3:0]  rk_round;
`ifdef DES_KEY_SCHEDULER_ABORT_EN
  logic        abort;
`endif

  int checks = 0;
  int errors = 0;

  des_key_scheduler dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .key_in   (key_in),
    .decrypt  (decrypt),
    .rk_ready (rk_ready),
`ifdef DES_KEY_SCHEDULER_ABORT_EN
    .abort    (abort),
`endif
    .rk       (rk),
    .rk_valid (rk_valid),
    .rk_round (rk_round),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Round key n (1..16) straight from the textbook definition: total left rotation of C0/D0
  function automatic logic [47:0] model_key(input logic [63:0] key, input int n);
    int   cum;
    logic c0 [28];
    logic d0 [28];
    logic cd [56];
    logic [47:0] r;
    cum = 0;
    for (int i = 0; i < n; i++) cum += SHIFTS[i];
    for (int j = 0; j < 28; j++) begin
      c0[j] = key[64-PC1[j]];
      d0[j] = key[64-PC1[j+28]];
    end
    for (int j = 0; j < 28; j++) begin
      cd[j]    = c0[(j + cum) % 28];
      cd[j+28] = d0[(j + cum) % 28];
    end
    for (int k = 0; k < 48; k++) r[47-k] = cd[PC2[k]-1];
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One schedule. poke_round: pulse start when that key is shown; poke_done: pulse start on done;
  // rst_round / abort_round: interrupt when that key is shown (-1 disables).
  task automatic run_sched(input logic [63:0] key, input logic dec, input bit rnd,
                           input int poke_round, input bit poke_done,
                           input int rst_round, input int abort_round,
                           output logic [47:0] first, output logic [47:0] last);
    logic [47:0] exp [16];
    logic [47:0] prev_rk;
    logic [3:0]  prev_rnd;
    bit          held, rdy, interrupted;
    int          nx, nd, dcyc;
    for (int e = 0; e < 16; e++) exp[e] = dec ? model_key(key, 16 - e) : model_key(key, e + 1);
    first = '0;
    last  = '0;
    nx = 0; nd = 0; dcyc = 0; held = 0; interrupted = 0;
    prev_rk = '0; prev_rnd = '0;
    @(negedge clk);
    key_in = key; decrypt = dec; start = 1'b1; rk_ready = 1'b0;
    @(negedge clk);
    start = 1'b0; key_in = {$urandom, $urandom}; decrypt = ~dec;
    for (int cyc = 1; cyc <= 300; cyc++) begin
      start = 1'b0;
      if (cyc > 1 && !busy) break;
      if (rk_valid) begin
        if (nx < 16) begin
          chk("rk", {16'h0, rk}, {16'h0, exp[nx]});
          chk("rk_round", {60'h0, rk_round}, nx);
          if (nx == 0)  first = rk;
          if (nx == 15) last  = rk;
        end else begin
          chk("extra_key_valid", {63'h0, rk_valid}, 64'h0);
        end
        if (held) begin
          chk("hold_rk", {16'h0, rk}, {16'h0, prev_rk});
          chk("hold_round", {60'h0, rk_round}, {60'h0, prev_rnd});
        end
      end
      if (done) begin
        nd++;
        dcyc = cyc;
      end
      if (rst_round >= 0 && rk_valid && nx == rst_round) begin
        rst_n = 1'b0;
        #1;
        chk("rst_outputs", {rk, rk_valid, rk_round, busy, done}, 64'h0);
        @(negedge clk);
        chk("rst_no_done", {63'h0, done}, 64'h0);
        rst_n = 1'b1;
        interrupted = 1;
        break;
      end
`ifdef DES_KEY_SCHEDULER_ABORT_EN
      if (abort_round >= 0 && rk_valid && nx == abort_round) begin
        abort = 1'b1; rk_ready = 1'b1;
        @(negedge clk);
        abort = 1'b0; rk_ready = 1'b0;
        chk("abort_valid", {63'h0, rk_valid}, 64'h0);
        chk("abort_busy",  {63'h0, busy}, 64'h0);
        chk("abort_done",  {63'h0, done}, 64'h0);
        interrupted = 1;
        break;
      end
`endif
      rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if ((rk_valid && nx == poke_round) || (done && poke_done)) begin
        start = 1'b1; key_in = {$urandom, $urandom}; decrypt = ~dec;
      end
      rk_ready = rdy;
      held     = rk_valid && !rdy;
      prev_rk  = rk;
      prev_rnd = rk_round;
      if (rk_valid && rdy) nx++;
      @(negedge clk);
    end
    start = 1'b0; rk_ready = 1'b0;
    if (!interrupted) begin
      chk("transfers", nx, 16);
      chk("done_pulses", nd, 1);
      // done lands 17 edges after acceptance: 18 cycles counting the start cycle
      if (!rnd) chk("latency", dcyc, 17);
      for (int i = 0; i < 2; i++) begin
        chk("idle_after", {62'h0, rk_valid, busy}, 64'h0);
        @(negedge clk);
      end
    end else begin
      chk("no_done_when_cut", nd, 0);
    end
  endtask

  typedef struct {
    logic [63:0] key;
    logic        dec;
    logic [47:0] first;
    logic [47:0] last;
  } vec_t;

  initial begin
    vec_t        vt [4];
    logic [63:0] k;
    logic [47:0] f, l;

    vt[0] = '{64'h133457799BBCDFF1, 1'b0, 48'h1B02EFFC7072, 48'hCB3D8B0E17F5};
    vt[1] = '{64'h133457799BBCDFF1, 1'b1, 48'hCB3D8B0E17F5, 48'h1B02EFFC7072};
    for (int i = 2; i < 4; i++) begin
      k = {$urandom, $urandom};
      vt[i].key   = k;
      vt[i].dec   = 1'(i - 2);
      vt[i].first = (i == 2) ? model_key(k, 1)  : model_key(k, 16);
      vt[i].last  = (i == 2) ? model_key(k, 16) : model_key(k, 1);
    end

    rst_n = 1'b0; start = 1'b0; decrypt = 1'b0; rk_ready = 1'b0; key_in = '0;
`ifdef DES_KEY_SCHEDULER_ABORT_EN
    abort = 1'b0;
`endif
    @(negedge clk);
    chk("reset_state", {rk, rk_valid, rk_round, busy, done}, 64'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_no_start", {62'h0, rk_valid, busy}, 64'h0);

    // Known-answer and random-key table at full rate
    for (int i = 0; i < 4; i++) begin
      run_sched(vt[i].key, vt[i].dec, 1'b0, -1, 1'b0, -1, -1, f, l);
      chk("tbl_first", {16'h0, f}, {16'h0, vt[i].first});
      chk("tbl_last",  {16'h0, l}, {16'h0, vt[i].last});
    end

    // Random backpressure with random keys and directions
    for (int i = 0; i < 4; i++)
      run_sched({$urandom, $urandom}, 1'($urandom_range(0, 1)), 1'b1, -1, 1'b0, -1, -1, f, l);

    // start pulsed at rk_round 5 and again with done: both ignored
    run_sched(64'h133457799BBCDFF1, 1'b0, 1'b0, 5, 1'b1, -1, -1, f, l);

    // Reset at rk_round 7, then a fresh schedule must start from K1
    run_sched(64'h133457799BBCDFF1, 1'b0, 1'b0, -1, 1'b0, 7, -1, f, l);
    run_sched(64'h133457799BBCDFF1, 1'b0, 1'b0, -1, 1'b0, -1, -1, f, l);
    chk("k1_after_reset", {16'h0, f}, 64'h1B02EFFC7072);

`ifdef DES_KEY_SCHEDULER_ABORT_EN
    // Abort with a simultaneous transfer at rk_round 3, then restart
    run_sched(64'h133457799BBCDFF1, 1'b0, 1'b0, -1, 1'b0, -1, 3, f, l);
    run_sched(64'h133457799BBCDFF1, 1'b1, 1'b0, -1, 1'b0, -1, -1, f, l);
    chk("first_after_abort", {16'h0, f}, 64'hCB3D8B0E17F5);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/des_key_scheduler.md
DES_KEY_SCHEDULER -- requirements
Module: des_key_scheduler

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk  in  1  rising-edge clock; rst_n  in  1  async active-low reset.
REQ-002 start  in  1  request to begin a 16-round key schedule; sampled only in IDLE.
REQ-003 key_in  in  64  DES key; FIPS bit 1 = key_in[63]; parity bits 8,16,...,64 are ignored.
REQ-004 decrypt  in  1  sampled with start; 0 = emit K1..K16, 1 = emit K16..K1.
REQ-005 rk_ready  in  1  consumer accepts rk on this cycle.
REQ-006 rk  out  48  current round key, FIPS bit 1 = rk[47].
REQ-007 rk_valid  out  1  rk and rk_round are valid.
REQ-008 rk_round  out  4  emission index 0..15 (0 = first key emitted).
REQ-009 busy  out  1  high from start acceptance until done.
REQ-010 done  out  1  one-cycle pulse after the 16th key is accepted.

Function
REQ-011 FSM states SHALL be IDLE, GEN, DONE.
REQ-012 In IDLE with start=1, the block SHALL compute C0/D0 = PC-1(key_in) as two 28-bit halves, latch decrypt, and enter GEN.
- Encrypt: register C1/D1 = C0/D0 rotated left by 1.
- Decrypt: register C0/D0 unrotated.
REQ-013 In GEN, rk SHALL equal PC-2 of the registered {C,D}, and rk_valid SHALL be 1.
- First rk_valid occurs the cycle after start is accepted.
REQ-014 A transfer SHALL occur when rk_valid && rk_ready; without a transfer, rk, rk_round and C/D SHALL hold.
REQ-015 On each transfer before the 16th, rk_round SHALL increment and C and D SHALL rotate independently:
- Encrypt: rotate left by the shift of the next round; shift is 1 for rounds 1, 2, 9 and 16, else 2.
- Decrypt: rotate right by 1 when the next emission index (1-based) is 2, 9 or 16, else by 2.
REQ-016 On the 16th transfer (rk_round=15), the FSM SHALL enter DONE.
- rk_valid SHALL drop the next cycle.
- In DONE, done=1 for exactly one cycle, then the FSM returns to IDLE.
REQ-017 start SHALL be ignored in GEN and DONE; start in the cycle done=1 SHALL NOT be accepted.
REQ-018 busy SHALL be 1 in GEN and DONE, and 0 in IDLE.
REQ-019 After 16 encrypt shifts (28 total), C/D SHALL equal C0/D0 (rotation wrap-around invariant).
REQ-020 rk_ready held high SHALL yield 16 keys on 16 consecutive cycles.
- Total start-to-done latency SHALL be 18 cycles.

Reset
REQ-021 Asserting rst_n low SHALL force the FSM to IDLE asynchronously and set the following values:
- rk=0, rk_valid=0, rk_round=0, busy=0, done=0.
- C/D=0, latched decrypt=0.
REQ-022 Reset during GEN SHALL abandon the schedule with no done pulse.
- After release, the block SHALL wait for a new start.

Configuration
REQ-023 Macro DES_KEY_SCHEDULER_ABORT_EN defined: the block SHALL have an extra input abort (1 bit).
- abort=1 in GEN or DONE SHALL return the FSM to IDLE next cycle, with rk_valid=0, busy=0 and no done pulse.
- abort SHALL take priority over a simultaneous transfer.
- abort in IDLE SHALL be ignored, and abort SHALL take priority over start.
REQ-024 Macro undefined: the abort port SHALL be absent, and schedules SHALL terminate only by completion or reset.

Verification
REQ-025 key_in=64'h133457799BBCDFF1, decrypt=0, rk_ready=1 -> rk_round 0: rk=48'h1B02EFFC7072; rk_round 15: rk=48'hCB3D8B0E17F5; done 18 cycles after start.
REQ-026 Same key, decrypt=1 -> rk_round 0: 48'hCB3D8B0E17F5; rk_round 15: 48'h1B02EFFC7072; the sequence is the exact reverse of REQ-025.
REQ-027 rk_ready toggled pseudo-randomly at 50% -> rk/rk_round stable while not ready, no key skipped or duplicated, exactly 16 transfers, one done pulse.
REQ-028 start pulsed during GEN (rk_round=5) and during done -> ignored; schedule completes unchanged; busy stays high until done.
REQ-029 rst_n low at rk_round=7 -> all outputs 0 immediately; no done; new start after release yields K1=48'h1B02EFFC7072.
REQ-030 With DES_KEY_SCHEDULER_ABORT_EN: abort together with a transfer at rk_round=3 -> rk_valid=0 next cycle, no done, busy=0; next start restarts at rk_round 0.
